// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with per-register pending-write scoreboard.
// NRD combinational read ports, one write port, register 0 reads as zero.
// A reserve marks a register pending until its write arrives. Busy_count tracks how many
// registers are pending.
// Optional feature: define REG_FILE_BYPASS_EN to forward the write port to the read ports
// in the same cycle.
module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int IDW   = $clog2(NREGS)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [NRD*IDW-1:0]  Rs_id,
  output logic [NRD*XLEN-1:0] Rs_data,
  output logic [NRD-1:0]      Rs_ready,
  input  logic                Wr_valid,
  input  logic [IDW-1:0]      Wr_id,
  input  logic [XLEN-1:0]     Wr_data,
  input  logic                Rsv_valid,
  input  logic [IDW-1:0]      Rsv_id,
  output logic                Rsv_ack,
  output logic [NREGS-1:0]    Pending,
  output logic [IDW:0]        Busy_count
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [IDW:0]     busy_q;
  logic             wr_en, rsv_set, ack_set, wr_clear;

  // Reserve arbitration. A pending register can be re-reserved only when its write lands
  // in the same cycle. A reserve on id 0 is always acked and has no effect.
  always_comb begin
    wr_en    = Wr_valid && (Wr_id != '0);
    Rsv_ack  = !Rst && Rsv_valid &&
               ((Rsv_id == '0) || !pend_q[Rsv_id] || (wr_en && (Wr_id == Rsv_id)));
    rsv_set  = Rsv_ack && (Rsv_id != '0);
    // A bit is counted only when it goes from clear to set. A re-reserve under a same-cycle
    // write leaves the count unchanged.
    ack_set  = rsv_set && !pend_q[Rsv_id];
    wr_clear = wr_en && pend_q[Wr_id] && !(rsv_set && (Rsv_id == Wr_id));
  end

  // Next scoreboard state. The write clears first, so a same-id reserve wins.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pend_d = pend_q;
    if (wr_en)   pend_d[Wr_id]  = 1'b0;
    if (rsv_set) pend_d[Rsv_id] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Scoreboard and busy counter registers. Reset drops all in-flight reservations.
  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pend_q <= '0;
      busy_q <= '0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_q + (IDW+1)'(ack_set) - (IDW+1)'(wr_clear);
    end
  end

  // Register storage. Entry 0 is never written and always reads as zero.
  // NOTE: the array must clear on reset, so it is built from resettable flops, not a RAM macro.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_en) begin
      regs[Wr_id] <= Wr_data;
    end
  end

  // Read ports are independent. While Rst is high they show zero data and report ready.
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [IDW-1:0] rd_id;
    logic           fwd;
    assign rd_id = Rs_id[g*IDW +: IDW];
`ifdef REG_FILE_BYPASS_EN
    assign fwd = wr_en && (Wr_id == rd_id);
`else
    assign fwd = 1'b0;
`endif
    assign Rs_data[g*XLEN +: XLEN] = (Rst || (rd_id == '0)) ? '0 :
                                     fwd ? Wr_data : regs[rd_id];
    assign Rs_ready[g] = Rst || fwd || !pend_q[rd_id];
  end

  assign Pending    = pend_q;
  assign Busy_count = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed steps followed by randomized traffic. Every output is compared
// against a behavioural model of the register file, which uses an array, a pending bitmap
// and a popcount.
module tb_reg_file_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int IDW   = $clog2(NREGS);
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*IDW-1:0]  rs_id;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_ready;
  logic                wr_valid;
  logic [IDW-1:0]      wr_id;
  logic [XLEN-1:0]     wr_data;
  logic                rsv_valid;
  logic [IDW-1:0]      rsv_id;
  logic                rsv_ack;
  logic [NREGS-1:0]    pending;
  logic [IDW:0]        busy_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [XLEN-1:0]  m_reg [NREGS];
  logic [NREGS-1:0] m_pend;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .Clk(clk), .Rst(rst), .Rs_id(rs_id), .Rs_data(rs_data), .Rs_ready(rs_ready),
    .Wr_valid(wr_valid), .Wr_id(wr_id), .Wr_data(wr_data),
    .Rsv_valid(rsv_valid), .Rsv_id(rsv_id), .Rsv_ack(rsv_ack),
    .Pending(pending), .Busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic wr_hits(input logic [IDW-1:0] id);
    return wr_valid && (wr_id != 0) && (wr_id == id);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input logic [IDW-1:0] id);
    if (rst || id == 0) return '0;
    if (BYPASS && wr_hits(id)) return wr_data;
    return m_reg[id];
  endfunction

  function automatic logic exp_ready(input logic [IDW-1:0] id);
    if (rst) return 1'b1;
    if (BYPASS && wr_hits(id)) return 1'b1;
    return !m_pend[id];
  endfunction

  function automatic logic exp_ack();
    if (rst || !rsv_valid) return 1'b0;
    return (rsv_id == 0) || !m_pend[rsv_id] || wr_hits(rsv_id);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) m_reg[r] = '0;
    m_pend = '0;
  endtask

  // Apply the effect of one clock edge to the model. The inputs are the values at the edge.
  task automatic model_edge();
    logic ack;
    if (rst) begin
      model_clear();
    end else begin
      ack = exp_ack();
      if (wr_valid && wr_id != 0) begin
        m_reg[wr_id]  = wr_data;
        m_pend[wr_id] = 1'b0;
      end
      if (ack && rsv_id != 0) m_pend[rsv_id] = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    for (int p = 0; p < NRD; p++) begin
      logic [IDW-1:0] id;
      id = rs_id[p*IDW +: IDW];
      check($sformatf("%s_data%0d", tag, p), 64'(rs_data[p*XLEN +: XLEN]), 64'(exp_data(id)));
      check($sformatf("%s_ready%0d", tag, p), 64'(rs_ready[p]), 64'(exp_ready(id)));
    end
    check({tag, "_ack"},     64'(rsv_ack),    64'(exp_ack()));
    check({tag, "_pending"}, 64'(pending),    64'(m_pend));
    check({tag, "_busy"},    64'(busy_count), 64'($countones(m_pend)));
  endtask

  // Inputs are driven 1 time unit after a posedge. settle samples 1 unit later.
  task automatic settle(input string tag);
    #1;
    check_model(tag);
  endtask

  task automatic edge_step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0; rsv_valid = 1'b0; wr_id = '0; rsv_id = '0; wr_data = '0;
  endtask

  task automatic set_rs(input int p, input logic [IDW-1:0] id);
    rs_id[p*IDW +: IDW] = id;
  endtask

  function automatic logic [IDW-1:0] rnd_id();
    if ($urandom_range(0, 3) == 0) return IDW'($urandom_range(0, NREGS-1));
    return IDW'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1'b0; rs_id = '0; idle();
    model_clear();

    // 1: async reset pulse mid-cycle. Outputs are forced even with traffic on the inputs.
    #3 rst = 1'b1;
    wr_valid = 1'b1; wr_id = 5'd3; wr_data = 32'hCAFE_0003;
    rsv_valid = 1'b1; rsv_id = 5'd4; set_rs(0, 5'd3); set_rs(1, 5'd0);
    #1;
    check("rst_ack", 64'(rsv_ack), 64'd0);
    check("rst_data0", 64'(rs_data[XLEN-1:0]), 64'd0);
    check("rst_ready", 64'(rs_ready), 64'h3);
    check("rst_busy", 64'(busy_count), 64'd0);
    check_model("rst");
    @(posedge clk); #1;
    rst = 1'b0; idle();
    for (int id = 0; id < NREGS; id++) begin
      set_rs(0, IDW'(id)); set_rs(1, IDW'(NREGS-1-id));
      settle("rd_all");
    end

    // 2: writes and reserves to id 0 have no effect.
    wr_valid = 1'b1; wr_id = '0; wr_data = 32'hDEAD_BEEF; set_rs(0, '0);
    settle("w0"); edge_step(); idle();
    settle("w0_rd");
    check("w0_data", 64'(rs_data[XLEN-1:0]), 64'd0);
    rsv_valid = 1'b1; rsv_id = '0;
    settle("r0");
    check("r0_ack", 64'(rsv_ack), 64'd1);
    edge_step(); idle();
    settle("r0_after");
    check("r0_pend0", 64'(pending[0]), 64'd0);

    // 3: reserve id 5, try again (WAW stall), then the write releases it.
    rsv_valid = 1'b1; rsv_id = 5'd5;
    settle("r5");
    check("r5_ack", 64'(rsv_ack), 64'd1);
    edge_step(); idle(); set_rs(0, 5'd5);
    settle("r5_held");
    check("r5_pend", 64'(pending[5]), 64'd1);
    check("r5_busy", 64'(busy_count), 64'd1);
    check("r5_ready", 64'(rs_ready[0]), 64'd0);
    rsv_valid = 1'b1; rsv_id = 5'd5;
    settle("r5_again");
    check("r5_again_ack", 64'(rsv_ack), 64'd0);
    edge_step(); idle();
    wr_valid = 1'b1; wr_id = 5'd5; wr_data = 32'h1234;
    settle("w5"); edge_step(); idle();
    settle("w5_after");
    check("w5_pend", 64'(pending[5]), 64'd0);
    check("w5_busy", 64'(busy_count), 64'd0);
    check("w5_data", 64'(rs_data[XLEN-1:0]), 64'h1234);

    // 4: same-cycle write and reserve on a pending id. The reserve wins.
    rsv_valid = 1'b1; rsv_id = 5'd7;
    settle("r7"); edge_step(); idle();
    wr_valid = 1'b1; wr_id = 5'd7; wr_data = 32'hA5;
    rsv_valid = 1'b1; rsv_id = 5'd7; set_rs(0, 5'd7);
    settle("wr7");
    check("wr7_ack", 64'(rsv_ack), 64'd1);
    edge_step(); idle();
    settle("wr7_after");
    check("wr7_pend", 64'(pending[7]), 64'd1);
    check("wr7_busy", 64'(busy_count), 64'd1);
    check("wr7_data", 64'(rs_data[XLEN-1:0]), 64'hA5);

    // 5: write to a pending id, read on port 1 in the same cycle.
    rsv_valid = 1'b1; rsv_id = 5'd3;
    settle("r3"); edge_step(); idle();
    wr_valid = 1'b1; wr_id = 5'd3; wr_data = 32'h55; set_rs(1, 5'd3);
    settle("w3");
`ifdef REG_FILE_BYPASS_EN
    check("w3_fwd_data", 64'(rs_data[XLEN +: XLEN]), 64'h55);
    check("w3_fwd_ready", 64'(rs_ready[1]), 64'd1);
`else
    check("w3_old_data", 64'(rs_data[XLEN +: XLEN]), 64'd0);
    check("w3_old_ready", 64'(rs_ready[1]), 64'd0);
`endif
    edge_step(); idle();
    settle("w3_after");
    check("w3_data", 64'(rs_data[XLEN +: XLEN]), 64'h55);
    check("w3_ready", 64'(rs_ready[1]), 64'd1);

    // 6: fill the scoreboard, then drop everything with an async reset mid-sequence.
    for (int id = 1; id < NREGS; id++) begin
      rsv_valid = 1'b1; rsv_id = IDW'(id);
      settle("fill"); edge_step();
    end
    idle();
    settle("full");
    check("full_busy", 64'(busy_count), 64'(NREGS-1));
    check("full_pend", 64'(pending), 64'({{(NREGS-1){1'b1}}, 1'b0}));
    for (int id = 1; id <= 10; id++) begin
      rsv_valid = 1'b1; rsv_id = IDW'(id);
      settle("refill"); edge_step();
    end
    settle("refill_end");
    rst = 1'b1;
    #1;
    model_clear();
    check("rst6_busy", 64'(busy_count), 64'd0);
    check("rst6_pend", 64'(pending), 64'd0);
    check_model("rst6");
    @(posedge clk); #1;
    rst = 1'b0; idle();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      wr_valid  = 1'($urandom_range(0, 1));
      wr_id     = rnd_id();
      wr_data   = $urandom;
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_id    = ($urandom_range(0, 2) == 0) ? wr_id : rnd_id();
      set_rs(0, rnd_id());
      set_rs(1, ($urandom_range(0, 2) == 0) ? wr_id : rnd_id());
      settle("rand");
      edge_step();
    end
    idle();
    settle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
